// File: rtl/sram_arb_pkg.sv
// Shared definitions for the SRAM access arbiter: FSM state encoding,
// the SRAM address window and the idle strobe pattern.
package sram_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2,
      ST_DONE   = 2'd3
   } arb_state_t;

   localparam logic [15:0] SRAM_BASE = 16'h0000;
   localparam logic [15:0] SRAM_TOP  = 16'h3FFF;

   // {CE_n, OE_n, WE_n} with every strobe released
   localparam logic [2:0] STROBE_IDLE = 3'b111;

   // Strobe pattern {CE_n, OE_n, WE_n} that a given state drives onto the SRAM.
   function automatic logic [2:0] strobe_for(input arb_state_t st, input logic is_wr);
      logic [2:0] s;
      s = STROBE_IDLE;
      case (st)
         ST_SETUP:  s = 3'b011;
         ST_ACCESS: s = is_wr ? 3'b010 : 3'b001;
         default:   s = STROBE_IDLE;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/sram_arb_rr.sv
// Two-way round-robin picker: when both ports request, the port named by
// ptr wins; a lone request always wins. Pure combinational.
module sram_arb_rr (
   input  logic [1:0] req,
   input  logic       ptr,
   output logic [1:0] grant
);

   // One-hot grant from the request pair and the preferred-port pointer
   always_comb begin
      grant = req;
      if (req == 2'b11) begin
         grant = ptr ? 2'b10 : 2'b01;
      end
   end

endmodule

// File: rtl/sram_access_arbiter.sv
// Shares one asynchronous SRAM between a writer (port 0) and a display
// reader (port 1). Arbitrates in IDLE, rejects addresses above SRAM_TOP
// with an err pulse, and sequences CE_n/OE_n/WE_n through
// IDLE -> SETUP -> ACCESS (WAIT_CYC cycles) -> DONE -> IDLE.
// All outputs are registered from the current state, so they trail the
// state by one clock.
// Build option: define SRAM_ARB_FIXED_PRIO_EN to give port 0 fixed priority
// (no round-robin pointer); otherwise arbitration is round-robin.
module sram_access_arbiter #(
   parameter int                ADDR_W   = 16,
   parameter int                DATA_W   = 8,
   parameter logic [ADDR_W-1:0] SRAM_TOP = ADDR_W'(16'h3FFF),
   parameter int                WAIT_CYC = 2
) (
   input  logic                  clk,
   input  logic                  nRESET,
   input  logic [1:0]            req,
   input  logic [1:0]            wr,
   input  logic [2*ADDR_W-1:0]   addr,
   input  logic [2*DATA_W-1:0]   wdata,
   output logic [1:0]            done,
   output logic [1:0]            err,
   output logic [DATA_W-1:0]     rdata,
   output logic                  busy,
   output logic [ADDR_W-1:0]     sram_addr,
   output logic [DATA_W-1:0]     sram_dout,
   input  logic [DATA_W-1:0]     sram_din,
   output logic                  sram_drv,
   output logic                  CE_n,
   output logic                  OE_n,
   output logic                  WE_n
);

   import sram_arb_pkg::*;

   localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYC - 1);

   arb_state_t          state_reg, state_next;
   logic [3:0]          wait_cnt_reg, wait_cnt_next;

   // Transaction latched at arbitration time
   logic                port_reg;
   logic                wr_reg;
   logic                err_flag_reg;
   logic [ADDR_W-1:0]   addr_lat_reg;
   logic [DATA_W-1:0]   wdata_lat_reg;

   // Next values of the registered outputs
   logic [2:0]          strobe_next;
   logic                drv_next;
   logic [1:0]          done_next;
   logic [1:0]          err_next;
   logic                busy_next;
   logic                capture_rd;

   logic [ADDR_W-1:0]   port_addr  [2];
   logic [DATA_W-1:0]   port_wdata [2];
   logic [1:0]          grant;
   logic                grant_port;
   logic                grant_valid;
   logic [ADDR_W-1:0]   sel_addr;

   // Split the packed per-port buses
   for (genvar gi = 0; gi < 2; gi++) begin : g_port
      assign port_addr[gi]  = addr[gi*ADDR_W +: ADDR_W];
      assign port_wdata[gi] = wdata[gi*DATA_W +: DATA_W];
   end

`ifdef SRAM_ARB_FIXED_PRIO_EN
   // Port 0 wins whenever it requests
   always_comb begin
      grant = 2'b00;
      if (req[0]) begin
         grant = 2'b01;
      end else if (req[1]) begin
         grant = 2'b10;
      end
   end
`else
   logic rr_ptr_reg;

   sram_arb_rr u_rr (
      .req   (req),
      .ptr   (rr_ptr_reg),
      .grant (grant)
   );

   // Point at the other port after every grant, including rejected ones
   always_ff @(posedge clk or negedge nRESET) begin
      if (!nRESET) begin
         rr_ptr_reg <= 1'b0;
      end else if (state_reg == ST_IDLE && grant != 2'b00) begin
         rr_ptr_reg <= grant[0];
      end
   end
`endif

   assign grant_valid = (grant != 2'b00);
   assign grant_port  = grant[1];
   assign sel_addr    = port_addr[grant_port];

   // State register and wait counter
   always_ff @(posedge clk or negedge nRESET) begin
      if (!nRESET) begin
         state_reg    <= ST_IDLE;
         wait_cnt_reg <= 4'd0;
      end else begin
         state_reg    <= state_next;
         wait_cnt_reg <= wait_cnt_next;
      end
   end

   // Next state plus the next value of every registered output
   always_comb begin
      state_next    = state_reg;
      wait_cnt_next = wait_cnt_reg;
      strobe_next   = strobe_for(state_reg, wr_reg);
      drv_next      = 1'b0;
      done_next     = 2'b00;
      err_next      = 2'b00;
      capture_rd    = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (grant_valid) begin
               state_next = (sel_addr > SRAM_TOP) ? ST_DONE : ST_SETUP;
            end
         end
         ST_SETUP: begin
            drv_next      = wr_reg;
            wait_cnt_next = WAIT_LAST;
            state_next    = ST_ACCESS;
         end
         ST_ACCESS: begin
            drv_next = wr_reg;
            if (wait_cnt_reg == 4'd0) begin
               state_next = ST_DONE;
            end else begin
               wait_cnt_next = wait_cnt_reg - 4'd1;
            end
         end
         ST_DONE: begin
            // sram_drv held through DONE so write data outlives WE_n
            drv_next   = wr_reg && !err_flag_reg;
            capture_rd = !wr_reg && !err_flag_reg;
            if (err_flag_reg) begin
               err_next = port_reg ? 2'b10 : 2'b01;
            end else begin
               done_next = port_reg ? 2'b10 : 2'b01;
            end
            state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
      busy_next = (state_next != ST_IDLE);
   end

   // Latch the winning request when leaving IDLE
   always_ff @(posedge clk or negedge nRESET) begin
      if (!nRESET) begin
         port_reg      <= 1'b0;
         wr_reg        <= 1'b0;
         err_flag_reg  <= 1'b0;
         addr_lat_reg  <= '0;
         wdata_lat_reg <= '0;
      end else if (state_reg == ST_IDLE && grant_valid) begin
         port_reg      <= grant_port;
         wr_reg        <= wr[grant_port];
         err_flag_reg  <= (sel_addr > SRAM_TOP);
         addr_lat_reg  <= sel_addr;
         wdata_lat_reg <= port_wdata[grant_port];
      end
   end

   // Output registers; rdata samples the bus on the edge ending ACCESS
   always_ff @(posedge clk or negedge nRESET) begin
      if (!nRESET) begin
         {CE_n, OE_n, WE_n} <= STROBE_IDLE;
         sram_drv           <= 1'b0;
         done               <= 2'b00;
         err                <= 2'b00;
         busy               <= 1'b0;
         rdata              <= '0;
         sram_addr          <= '0;
         sram_dout          <= '0;
      end else begin
         {CE_n, OE_n, WE_n} <= strobe_next;
         sram_drv           <= drv_next;
         done               <= done_next;
         err                <= err_next;
         busy               <= busy_next;
         if (state_reg == ST_SETUP) begin
            sram_addr <= addr_lat_reg;
            sram_dout <= wdata_lat_reg;
         end
         if (capture_rd) begin
            rdata <= sram_din;
         end
      end
   end

endmodule
